vend_ctrl_multi: RTL and testbench

//   Parametrised multi-item vending controller; generalises the fixed 30-cent coin FSM.
//   - Accumulates credit in cents from the existing 2-bit coin encoding.
//   - Sells one of N_ITEMS at per-item prices; supports cancel/refund.
//   - Pays change one coin at a time to a coin hopper over a valid/ack handshake.

---
 rtl/vend_pkg.sv | 25 ++
 rtl/vend_change_pick.sv | 23 ++
 rtl/vend_ctrl_multi.sv | 183 ++++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: coin encodings, coin value
// lookup and the controller state type.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    CHANGE = 1'b1
  } vend_state_e;

  // Face value in cents of a 2-bit coin code; COIN_NONE is worth nothing.
  function automatic logic [4:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_5:  return 5'd5;
      COIN_10: return 5'd10;
      COIN_25: return 5'd25;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_pick.sv
// Greedy change selector: largest coin of 25/10/5 not exceeding the credit.
// Credit is always a multiple of 5, so repeated picks always reach zero.
module vend_change_pick
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [1:0]          o_chg_coin
);

  // Pick the largest coin that still fits into the remaining credit.
  always_comb begin
    o_chg_coin = COIN_NONE;
    if (i_credit >= CREDIT_W'(25))
      o_chg_coin = COIN_25;
    else if (i_credit >= CREDIT_W'(10))
      o_chg_coin = COIN_10;
    else if (i_credit >= CREDIT_W'(5))
      o_chg_coin = COIN_5;
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: accumulates coin credit, sells one of
// N_ITEMS at per-item prices, refunds on cancel and pays change one coin at
// a time over a valid/ack handshake to the coin hopper.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | accept coins, selections and cancel
//   CHANGE | pay out remaining credit coin by coin; coins/sels refused
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int                            N_ITEMS     = 4,
  parameter int                            CREDIT_W    = 8,
  parameter int                            CREDIT_MAX  = 200,
  parameter logic [N_ITEMS*CREDIT_W-1:0]   ITEM_PRICES = {8'd50, 8'd45, 8'd35, 8'd30},
  localparam int                           SEL_W       = $clog2(N_ITEMS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_item,
  input  logic                cancel,
  output logic                dispense,
  output logic [SEL_W-1:0]    dispense_item,
  output logic                coin_reject,
  output logic                sel_err,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // Parameter sanity: prices and ceiling must be multiples of 5 so greedy
  // change always terminates exactly at zero.
  function automatic bit f_params_ok();
    bit ok;
    int p;
    ok = (N_ITEMS >= 2) && (CREDIT_MAX % 5 == 0) && (CREDIT_W < 31) &&
         (CREDIT_MAX < (1 << CREDIT_W)) && (CREDIT_W >= 5);
    for (int i = 0; i < N_ITEMS; i++) begin
      p = int'(ITEM_PRICES[i*CREDIT_W +: CREDIT_W]);
      if (p == 0 || (p % 5) != 0) ok = 1'b0;
    end
    return ok;
  endfunction

  if (!f_params_ok()) begin : g_param_check
    $error("vend_ctrl_multi: illegal parameter set");
  end

  localparam logic [CREDIT_W:0] MAX_EXT = (CREDIT_W+1)'(CREDIT_MAX);

  vend_state_e         r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_chg_valid;
  logic [1:0]          r_chg_coin;
  logic                r_busy;
  logic                r_dispense;
  logic [SEL_W-1:0]    r_dispense_item;
  logic                r_coin_reject;
  logic                r_sel_err;

  vend_state_e         w_state_nxt;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic [CREDIT_W-1:0] w_credit_pc;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W:0]   w_coin_val;
  logic [CREDIT_W-1:0] w_chg_val;
  logic                w_coin_live;
  logic [CREDIT_W-1:0] w_price;
  logic                w_sel_in_range;
  logic                w_dispense_nxt;
  logic [SEL_W-1:0]    w_item_nxt;
  logic                w_reject_nxt;
  logic                w_sel_err_nxt;
  logic [1:0]          w_pick;

  // Change coin is chosen from the credit that will be held next cycle, so
  // the registered chg_coin only moves when the credit does (i.e. on ack).
  vend_change_pick #(.CREDIT_W(CREDIT_W)) u_pick (
    .i_credit   (w_credit_nxt),
    .o_chg_coin (w_pick)
  );

  // Price lookup; indices beyond N_ITEMS (possible when N_ITEMS is not a
  // power of two) leave w_sel_in_range low.
  always_comb begin
    w_price        = '0;
    w_sel_in_range = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel_item == SEL_W'(i)) begin
        w_price        = ITEM_PRICES[i*CREDIT_W +: CREDIT_W];
        w_sel_in_range = 1'b1;
      end
    end
  end

  // Next-state / next-credit / pulse decision for the current cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_coin_live    = coin_valid && (coin != COIN_NONE);
    w_coin_val     = (CREDIT_W+1)'(coin_value(coin));
    w_sum          = {1'b0, r_credit} + w_coin_val;
    w_chg_val      = CREDIT_W'(coin_value(r_chg_coin));
    w_credit_pc    = r_credit;
    w_credit_nxt   = r_credit;
    w_dispense_nxt = 1'b0;
    w_item_nxt     = '0;
    w_reject_nxt   = 1'b0;
    w_sel_err_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_coin_live) begin
          if (w_sum > MAX_EXT)
            w_reject_nxt = 1'b1;
          else
            w_credit_pc = w_sum[CREDIT_W-1:0];
        end
        w_credit_nxt = w_credit_pc;
        if (cancel) begin
          if (w_credit_pc != '0) w_state_nxt = CHANGE;
          if (sel_valid) w_sel_err_nxt = 1'b1;
        end else if (sel_valid) begin
          if (w_sel_in_range && (w_credit_pc >= w_price)) begin
            w_dispense_nxt = 1'b1;
            w_item_nxt     = sel_item;
            w_credit_nxt   = w_credit_pc - w_price;
            if (w_credit_nxt != '0) w_state_nxt = CHANGE;
          end else begin
            w_sel_err_nxt = 1'b1;
          end
        end
      end
      CHANGE: begin
        if (w_coin_live) w_reject_nxt = 1'b1;
        if (sel_valid) w_sel_err_nxt = 1'b1;
        if (r_chg_valid && chg_ack) begin
          w_credit_nxt = r_credit - w_chg_val;
          if (w_credit_nxt == '0) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, credit and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_credit        <= '0;
      r_chg_valid     <= 1'b0;
      r_chg_coin      <= COIN_NONE;
      r_busy          <= 1'b0;
      r_dispense      <= 1'b0;
      r_dispense_item <= '0;
      r_coin_reject   <= 1'b0;
      r_sel_err       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_credit        <= w_credit_nxt;
      r_chg_valid     <= (w_state_nxt == CHANGE);
      r_chg_coin      <= (w_state_nxt == CHANGE) ? w_pick : COIN_NONE;
      r_busy          <= (w_state_nxt == CHANGE);
      r_dispense      <= w_dispense_nxt;
      r_dispense_item <= w_item_nxt;
      r_coin_reject   <= w_reject_nxt;
      r_sel_err       <= w_sel_err_nxt;
    end
  end

  assign dispense      = r_dispense;
  assign dispense_item = r_dispense_item;
  assign coin_reject   = r_coin_reject;
  assign sel_err       = r_sel_err;
  assign chg_valid     = r_chg_valid;
  assign chg_coin      = r_chg_coin;
  assign credit        = r_credit;
  assign busy          = r_busy;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Bench for vend_ctrl_multi: pulse outputs are scored against a queue of
// expected events; credit and change handshake are checked inline.
module tb_vend_ctrl_multi;

  localparam logic [1:0] C0  = 2'b00;
  localparam logic [1:0] C5  = 2'b01;
  localparam logic [1:0] C10 = 2'b10;
  localparam logic [1:0] C25 = 2'b11;

  typedef struct packed {
    logic       disp;
    logic       rej;
    logic       err;
    logic [1:0] item;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'b00;
  logic       cancel = 1'b0;
  logic       chg_ack = 1'b0;
  logic       dispense, coin_reject, sel_err, chg_valid, busy;
  logic [1:0] dispense_item, chg_coin;
  logic [7:0] credit;

  logic       u2_coin_valid = 1'b0;
  logic [1:0] u2_coin = 2'b00;
  logic       u2_sel_valid = 1'b0;
  logic [1:0] u2_sel_item = 2'b00;
  logic       u2_cancel = 1'b0;
  logic       u2_chg_ack = 1'b0;
  logic       u2_dispense, u2_coin_reject, u2_sel_err, u2_chg_valid, u2_busy;
  logic [1:0] u2_dispense_item, u2_chg_coin;
  logic [7:0] u2_credit;

  int  n_checks = 0;
  int  n_errors = 0;
  ev_t q[$];
  ev_t mon_e;

  always #5 clk = ~clk;

  vend_ctrl_multi dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
    .dispense(dispense), .dispense_item(dispense_item),
    .coin_reject(coin_reject), .sel_err(sel_err),
    .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ack(chg_ack),
    .credit(credit), .busy(busy)
  );

  // Three items so that sel_item = 3 is out of range.
  vend_ctrl_multi #(.N_ITEMS(3), .ITEM_PRICES({8'd45, 8'd35, 8'd30})) dut3 (
    .clk(clk), .rst(rst), .coin_valid(u2_coin_valid), .coin(u2_coin),
    .sel_valid(u2_sel_valid), .sel_item(u2_sel_item), .cancel(u2_cancel),
    .dispense(u2_dispense), .dispense_item(u2_dispense_item),
    .coin_reject(u2_coin_reject), .sel_err(u2_sel_err),
    .chg_valid(u2_chg_valid), .chg_coin(u2_chg_coin), .chg_ack(u2_chg_ack),
    .credit(u2_credit), .busy(u2_busy)
  );

  // Scoreboard: every pulse seen must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (dispense || coin_reject || sel_err)) begin
      n_checks++;
      if (q.size() == 0) begin
        n_errors++;
        $display("FAIL pulse_unexpected: got disp=%0b rej=%0b err=%0b item=%0d, required no pulse",
                 dispense, coin_reject, sel_err, dispense_item);
      end else begin
        mon_e = q.pop_front();
        if ({dispense, coin_reject, sel_err, dispense_item} !==
            {mon_e.disp, mon_e.rej, mon_e.err, mon_e.item}) begin
          n_errors++;
          $display("FAIL pulse_match: got disp=%0b rej=%0b err=%0b item=%0d, required disp=%0b rej=%0b err=%0b item=%0d",
                   dispense, coin_reject, sel_err, dispense_item,
                   mon_e.disp, mon_e.rej, mon_e.err, mon_e.item);
        end
      end
    end
  end

  function automatic ev_t mk_ev(input logic d, input logic r, input logic e, input logic [1:0] it);
    ev_t v;
    v.disp = d; v.rej = r; v.err = e; v.item = it;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] c, input bit rej);
    coin_valid = 1'b1;
    coin = c;
    if (rej) q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 2'd0));
    tick();
    coin_valid = 1'b0;
    coin = C0;
  endtask

  task automatic do_sel(input logic [1:0] it, input bit ok);
    sel_valid = 1'b1;
    sel_item = it;
    q.push_back(ok ? mk_ev(1'b1, 1'b0, 1'b0, it) : mk_ev(1'b0, 1'b0, 1'b1, 2'd0));
    tick();
    sel_valid = 1'b0;
    sel_item = 2'd0;
  endtask

  task automatic do_ack();
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
  endtask

  task automatic drain(input string name);
    tick();
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: got %0d pending pulses, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if ({dispense, coin_reject, sel_err, chg_valid, busy, chg_coin, dispense_item, credit} !== 15'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got d=%0b r=%0b e=%0b v=%0b b=%0b cc=%0d di=%0d cr=%0d, required all 0",
               dispense, coin_reject, sel_err, chg_valid, busy, chg_coin, dispense_item, credit);
    end
  endtask

  task automatic test_exact_sale();
    put_coin(C10, 0);
    put_coin(C10, 0);
    put_coin(C10, 0);
    n_checks++;
    if (credit !== 8'd30) begin n_errors++; $display("FAIL t1_credit30: got %0d, required 30", credit); end
    do_sel(2'd0, 1);
    n_checks++;
    if (dispense !== 1'b1 || dispense_item !== 2'd0) begin
      n_errors++; $display("FAIL t1_dispense: got %0b/%0d, required 1/0", dispense, dispense_item);
    end
    n_checks++;
    if (credit !== 8'd0 || chg_valid !== 1'b0) begin
      n_errors++; $display("FAIL t1_after: got credit=%0d chg_valid=%0b, required 0/0", credit, chg_valid);
    end
    drain("t1");
    n_checks++;
    if (dispense !== 1'b0 || chg_valid !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL t1_idle: got disp=%0b chg_valid=%0b busy=%0b, required 0", dispense, chg_valid, busy);
    end
  endtask

  task automatic test_change_sale();
    put_coin(C25, 0);
    put_coin(C25, 0);
    do_sel(2'd0, 1);
    n_checks++;
    if (credit !== 8'd20 || chg_valid !== 1'b1 || chg_coin !== C10 || busy !== 1'b1) begin
      n_errors++; $display("FAIL t2_change_start: got cr=%0d v=%0b cc=%0d b=%0b, required 20/1/2/1",
                           credit, chg_valid, chg_coin, busy);
    end
    do_ack();
    n_checks++;
    if (credit !== 8'd10 || chg_valid !== 1'b1 || chg_coin !== C10) begin
      n_errors++; $display("FAIL t2_ack1: got cr=%0d v=%0b cc=%0d, required 10/1/2", credit, chg_valid, chg_coin);
    end
    do_ack();
    n_checks++;
    if (credit !== 8'd0 || chg_valid !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL t2_ack2: got cr=%0d v=%0b b=%0b, required 0/0/0", credit, chg_valid, busy);
    end
    drain("t2");
  endtask

  task automatic test_sel_err_cancel();
    put_coin(C25, 0);
    do_sel(2'd3, 0);
    n_checks++;
    if (credit !== 8'd25 || chg_valid !== 1'b0) begin
      n_errors++; $display("FAIL t3_selerr: got cr=%0d v=%0b, required 25/0", credit, chg_valid);
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_checks++;
    if (chg_valid !== 1'b1 || chg_coin !== C25 || credit !== 8'd25) begin
      n_errors++; $display("FAIL t3_cancel: got v=%0b cc=%0d cr=%0d, required 1/3/25", chg_valid, chg_coin, credit);
    end
    do_ack();
    n_checks++;
    if (credit !== 8'd0 || chg_valid !== 1'b0) begin
      n_errors++; $display("FAIL t3_refund: got cr=%0d v=%0b, required 0/0", credit, chg_valid);
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_checks++;
    if (chg_valid !== 1'b0 || credit !== 8'd0) begin
      n_errors++; $display("FAIL t3_cancel_zero: got v=%0b cr=%0d, required 0/0", chg_valid, credit);
    end
    drain("t3");
  endtask

  task automatic test_credit_max();
    for (int i = 0; i < 8; i++) put_coin(C25, 0);
    n_checks++;
    if (credit !== 8'd200) begin n_errors++; $display("FAIL t4_credit200: got %0d, required 200", credit); end
    put_coin(C5, 1);
    n_checks++;
    if (credit !== 8'd200) begin n_errors++; $display("FAIL t4_reject5: got %0d, required 200", credit); end
    coin_valid = 1'b1; coin = C0;
    tick();
    coin_valid = 1'b0;
    n_checks++;
    if (coin_reject !== 1'b0 || credit !== 8'd200) begin
      n_errors++; $display("FAIL t4_none_coin: got rej=%0b cr=%0d, required 0/200", coin_reject, credit);
    end
    do_sel(2'd3, 1);
    n_checks++;
    if (credit !== 8'd150 || chg_coin !== C25) begin
      n_errors++; $display("FAIL t4_sell: got cr=%0d cc=%0d, required 150/3", credit, chg_coin);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (chg_valid !== 1'b1 || chg_coin !== C25) begin
        n_errors++; $display("FAIL t4_payout%0d: got v=%0b cc=%0d, required 1/3", i, chg_valid, chg_coin);
      end
      do_ack();
    end
    n_checks++;
    if (credit !== 8'd0 || chg_valid !== 1'b0) begin
      n_errors++; $display("FAIL t4_done: got cr=%0d v=%0b, required 0/0", credit, chg_valid);
    end
    drain("t4");
  endtask

  task automatic test_ack_hold();
    put_coin(C25, 0);
    put_coin(C10, 0);
    do_sel(2'd0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin coin_valid = 1'b1; coin = C10; q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 2'd0)); end
      if (i == 2) begin sel_valid = 1'b1; sel_item = 2'd0; q.push_back(mk_ev(1'b0, 1'b0, 1'b1, 2'd0)); end
      if (i == 3) cancel = 1'b1;
      n_checks++;
      if (chg_valid !== 1'b1 || chg_coin !== C5 || credit !== 8'd5) begin
        n_errors++; $display("FAIL t5_hold%0d: got v=%0b cc=%0d cr=%0d, required 1/1/5", i, chg_valid, chg_coin, credit);
      end
      tick();
      coin_valid = 1'b0; coin = C0; sel_valid = 1'b0; cancel = 1'b0;
    end
    do_ack();
    n_checks++;
    if (credit !== 8'd0 || chg_valid !== 1'b0) begin
      n_errors++; $display("FAIL t5_done: got cr=%0d v=%0b, required 0/0", credit, chg_valid);
    end
    drain("t5");
  endtask

  task automatic test_back_to_back();
    put_coin(C25, 0);
    coin_valid = 1'b1; coin = C10;
    do_sel(2'd1, 1);
    coin_valid = 1'b0; coin = C0;
    n_checks++;
    if (credit !== 8'd0 || chg_valid !== 1'b0) begin
      n_errors++; $display("FAIL b2b_sale: got cr=%0d v=%0b, required 0/0", credit, chg_valid);
    end
    coin_valid = 1'b1; coin = C25; cancel = 1'b1;
    do_sel(2'd0, 0);
    coin_valid = 1'b0; coin = C0; cancel = 1'b0;
    n_checks++;
    if (credit !== 8'd25 || chg_valid !== 1'b1 || chg_coin !== C25) begin
      n_errors++; $display("FAIL b2b_cancel: got cr=%0d v=%0b cc=%0d, required 25/1/3", credit, chg_valid, chg_coin);
    end
    do_ack();
    drain("b2b");
  endtask

  task automatic test_reset_mid_change();
    put_coin(C10, 0);
    put_coin(C5, 0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_checks++;
    if (credit !== 8'd15 || chg_valid !== 1'b1 || chg_coin !== C10) begin
      n_errors++; $display("FAIL t6_change: got cr=%0d v=%0b cc=%0d, required 15/1/2", credit, chg_valid, chg_coin);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({dispense, coin_reject, sel_err, chg_valid, busy, chg_coin, dispense_item, credit} !== 15'd0) begin
      n_errors++; $display("FAIL t6_reset: got v=%0b b=%0b cc=%0d cr=%0d, required all 0", chg_valid, busy, chg_coin, credit);
    end
    put_coin(C5, 0);
    n_checks++;
    if (credit !== 8'd5 || chg_valid !== 1'b0) begin
      n_errors++; $display("FAIL t6_coin: got cr=%0d v=%0b, required 5/0", credit, chg_valid);
    end
    do_ack();
    n_checks++;
    if (credit !== 8'd5) begin n_errors++; $display("FAIL t6_stray_ack: got %0d, required 5", credit); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_checks++;
    if (chg_coin !== C5 || chg_valid !== 1'b1) begin
      n_errors++; $display("FAIL t6_refund: got cc=%0d v=%0b, required 1/1", chg_coin, chg_valid);
    end
    do_ack();
    drain("t6");
  endtask

  task automatic test_range();
    u2_coin_valid = 1'b1; u2_coin = C25;
    tick(); tick();
    u2_coin_valid = 1'b0; u2_coin = C0;
    u2_sel_valid = 1'b1; u2_sel_item = 2'd3;
    tick();
    u2_sel_valid = 1'b0;
    n_checks++;
    if (u2_sel_err !== 1'b1 || u2_dispense !== 1'b0 || u2_credit !== 8'd50) begin
      n_errors++; $display("FAIL range_oob: got err=%0b disp=%0b cr=%0d, required 1/0/50", u2_sel_err, u2_dispense, u2_credit);
    end
    u2_sel_valid = 1'b1; u2_sel_item = 2'd2;
    tick();
    u2_sel_valid = 1'b0;
    n_checks++;
    if (u2_dispense !== 1'b1 || u2_dispense_item !== 2'd2 || u2_credit !== 8'd5 || u2_chg_coin !== C5) begin
      n_errors++; $display("FAIL range_top: got disp=%0b it=%0d cr=%0d cc=%0d, required 1/2/5/1",
                           u2_dispense, u2_dispense_item, u2_credit, u2_chg_coin);
    end
    u2_chg_ack = 1'b1;
    tick();
    u2_chg_ack = 1'b0;
    n_checks++;
    if (u2_dispense !== 1'b0 || u2_credit !== 8'd0 || u2_chg_valid !== 1'b0) begin
      n_errors++; $display("FAIL range_done: got disp=%0b cr=%0d v=%0b, required 0/0/0", u2_dispense, u2_credit, u2_chg_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_exact_sale();
    test_change_sale();
    test_sel_err_cancel();
    test_credit_max();
    test_ack_hold();
    test_back_to_back();
    test_reset_mid_change();
    test_range();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
